// File: rtl/vga_scanout_if.sv
// Framebuffer read port and VGA DAC pins for the VGA scan-out block.
// The master side is the scan-out engine; the slave side is the
// framebuffer RAM plus the DAC/board.
interface vga_scanout_if;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;
    logic        frame_start;
    logic        vblank;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic [9:0]  VGA_R;
    logic [9:0]  VGA_G;
    logic [9:0]  VGA_B;

    modport master (
        output rd_addr,
        input  rd_data,
        output frame_start,
        output vblank,
        output VGA_CLK,
        output VGA_HS,
        output VGA_VS,
        output VGA_BLANK_N,
        output VGA_SYNC_N,
        output VGA_R,
        output VGA_G,
        output VGA_B
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  frame_start,
        input  vblank,
        input  VGA_CLK,
        input  VGA_HS,
        input  VGA_VS,
        input  VGA_BLANK_N,
        input  VGA_SYNC_N,
        input  VGA_R,
        input  VGA_G,
        input  VGA_B
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out engine: 640x480 timing from a 50 MHz clock using a
// half-rate pixel enable, reading a 160x120 3-bit framebuffer with 4x4
// pixel replication. Colour, syncs, blank and vblank are all registered
// from the same counter value so they leave the block aligned.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic         clk,
    input  logic         resetn,
    vga_scanout_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_VIS_C    = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_LO  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_C    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_LO  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    // Replicate one colour bit across a 10-bit DAC channel, forced to
    // black outside the visible window.
    function automatic logic [9:0] expand_channel(input logic bit_in, input logic en);
        return (bit_in & en) ? 10'h3FF : 10'h000;
    endfunction

    logic        pix_en_r;
    logic        vga_clk_r;
    logic [9:0]  hcount_r;
    logic [9:0]  vcount_r;
    logic        frame_start_r;
    logic        vblank_r;
    logic        hs_r;
    logic        vs_r;
    logic        blank_n_r;
    logic [9:0]  red_r;
    logic [9:0]  green_r;
    logic [9:0]  blue_r;

    logic        h_last_s;
    logic        v_last_s;
    logic        visible_s;
    logic        hs_active_s;
    logic        vs_active_s;
    logic [7:0]  x_s;
    logic [6:0]  y_s;
    logic [14:0] rd_addr_s;

    // Decode the current counter value: wrap points, window, syncs, address.
    always_comb begin
        h_last_s    = (hcount_r == H_LAST);
        v_last_s    = (vcount_r == V_LAST);
        visible_s   = (hcount_r < H_VIS_C) && (vcount_r < V_VIS_C);
        hs_active_s = (hcount_r >= H_SYNC_LO) && (hcount_r < H_SYNC_HI);
        vs_active_s = (vcount_r >= V_SYNC_LO) && (vcount_r < V_SYNC_HI);
        x_s         = hcount_r[9:2];
        y_s         = vcount_r[8:2];
        // y*160 + x built from shifts: y*128 + y*32 + x
        rd_addr_s   = ({8'd0, y_s} << 7) + ({8'd0, y_s} << 5) + {7'd0, x_s};
    end

    // Pixel enable toggles every clk; VGA_CLK tracks it so the DAC sees
    // a rising edge half a pixel after each output update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en_r  <= 1'b0;
            vga_clk_r <= 1'b0;
        end else begin
            pix_en_r  <= ~pix_en_r;
            vga_clk_r <= ~pix_en_r;
        end
    end

    // Horizontal/vertical raster counters, advancing once per pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else if (pix_en_r) begin
            if (h_last_s) begin
                hcount_r <= 10'd0;
                if (v_last_s) begin
                    vcount_r <= 10'd0;
                end else begin
                    vcount_r <= vcount_r + 10'd1;
                end
            end else begin
                hcount_r <= hcount_r + 10'd1;
            end
        end else begin
            hcount_r <= hcount_r;
            vcount_r <= vcount_r;
        end
    end

    // One-clk frame_start when the counters wrap to (0,0); never fires on
    // the first frame after reset because reset lands on (0,0) without a wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pix_en_r & h_last_s & v_last_s;
        end
    end

    // Pixel outputs, all registered from the same counter value on pix_en.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            blank_n_r <= 1'b0;
            vblank_r  <= 1'b0;
            red_r     <= 10'h000;
            green_r   <= 10'h000;
            blue_r    <= 10'h000;
        end else if (pix_en_r) begin
            hs_r      <= ~hs_active_s;
            vs_r      <= ~vs_active_s;
            blank_n_r <= visible_s;
            vblank_r  <= (vcount_r >= V_VIS_C);
            red_r     <= expand_channel(vga.rd_data[2], visible_s);
            green_r   <= expand_channel(vga.rd_data[1], visible_s);
            blue_r    <= expand_channel(vga.rd_data[0], visible_s);
        end else begin
            hs_r      <= hs_r;
            vs_r      <= vs_r;
            blank_n_r <= blank_n_r;
            vblank_r  <= vblank_r;
            red_r     <= red_r;
            green_r   <= green_r;
            blue_r    <= blue_r;
        end
    end

    assign vga.rd_addr     = rd_addr_s;
    assign vga.frame_start = frame_start_r;
    assign vga.vblank      = vblank_r;
    assign vga.VGA_CLK     = vga_clk_r;
    assign vga.VGA_HS      = hs_r;
    assign vga.VGA_VS      = vs_r;
    assign vga.VGA_BLANK_N = blank_n_r;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_R       = red_r;
    assign vga.VGA_G       = green_r;
    assign vga.VGA_B       = blue_r;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout. Instance A uses the default 640x480
// timing with a RAM returning addr[2:0]; instance B uses a shrunken raster
// (32x20 total) with a RAM returning 3'b111 so whole frames fit in a short run.
module tb_vga_scanout;

    logic clk;
    logic resetn_a;
    logic resetn_b;
    int   checks;
    int   errors;

    vga_scanout_if ifa ();
    vga_scanout_if ifb ();

    vga_scanout u_dut_a (
        .clk    (clk),
        .resetn (resetn_a),
        .vga    (ifa.master)
    );

    vga_scanout #(
        .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
        .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (4)
    ) u_dut_b (
        .clk    (clk),
        .resetn (resetn_b),
        .vga    (ifb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous one-clk-latency RAM models
    always @(posedge clk) ifa.rd_data <= ifa.rd_addr[2:0];
    always @(posedge clk) ifb.rd_data <= 3'b111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return ifa.VGA_HS;
            1:       return ifa.VGA_BLANK_N;
            default: return 1'b0;
        endcase
    endfunction

    // Count clks until the selected signal of instance A reaches val (bounded)
    task automatic wait_for(input int sel, input logic val, input int max_clk, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (get_sig(sel) !== val && n < max_clk);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int p;
        int h;
        int v;
        logic e_hs, e_vs, e_bn, e_vb, e_fs;
        int fs_count;
        int fs_first;
        int fs_second;
        int bn_clks;
        int hs_clks;
        int vs_clks;

        checks   = 0;
        errors   = 0;
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        ifa.rd_data = 3'b000;
        ifb.rd_data = 3'b000;
        #23;

        // Reset state
        check("rst_hs",      32'(ifa.VGA_HS), 32'd1);
        check("rst_vs",      32'(ifa.VGA_VS), 32'd1);
        check("rst_blank_n", 32'(ifa.VGA_BLANK_N), 32'd0);
        check("rst_rgb",     {2'b00, ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}, 32'd0);
        check("rst_fs",      32'(ifa.frame_start), 32'd0);
        check("rst_vblank",  32'(ifa.vblank), 32'd0);
        check("rst_vga_clk", 32'(ifa.VGA_CLK), 32'd0);
        check("sync_n",      32'(ifa.VGA_SYNC_N), 32'd0);
        check("rst_b_hs",    32'(ifb.VGA_HS), 32'd1);
        check("rst_b_vclk",  32'(ifb.VGA_CLK), 32'd0);

        // ---- Instance A: line timing ----
        @(negedge clk);
        resetn_a = 1'b1;
        wait_for(1, 1'b1, 10, n);   check("first_blank_rise", 32'(n), 32'd2);
        wait_for(1, 1'b0, 2000, n); check("blank_high_clks", 32'(n), 32'd1280);
        wait_for(0, 1'b0, 2000, n); check("hs_fall_after_blank", 32'(n), 32'd32);
        wait_for(0, 1'b1, 2000, n); check("hs_low_clks", 32'(n), 32'd192);
        wait_for(1, 1'b1, 2000, n); check("line1_blank_rise", 32'(n), 32'd96);
        wait_for(0, 1'b0, 2000, n); check("line1_hs_fall", 32'(n), 32'd1312);
        check("vs_high_line1", 32'(ifa.VGA_VS), 32'd1);

        // hcount=8, vcount=4 presented after clk 6416 from release
        wait_clks(6416 - 2914);
        check("rd_addr_8_4", 32'(ifa.rd_addr), 32'd162);
        wait_clks(2);
        check("pix_8_4_blank_n", 32'(ifa.VGA_BLANK_N), 32'd1);
        check("pix_8_4_g", 32'(ifa.VGA_G), 32'h3FF);
        check("pix_8_4_r", 32'(ifa.VGA_R), 32'd0);
        check("pix_8_4_b", 32'(ifa.VGA_B), 32'd0);

        // Reset inside the HS pulse of line 4 (hcount ~700)
        wait_for(0, 1'b0, 2000, n); check("line4_hs_fall", 32'(n), 32'd1296);
        wait_clks(88);
        check("hs_low_at_700", 32'(ifa.VGA_HS), 32'd0);
        resetn_a = 1'b0;
        #1;
        check("mid_rst_hs", 32'(ifa.VGA_HS), 32'd1);
        check("mid_rst_blank_n", 32'(ifa.VGA_BLANK_N), 32'd0);
        check("mid_rst_vga_clk", 32'(ifa.VGA_CLK), 32'd0);
        @(negedge clk);
        resetn_a = 1'b1;
        wait_for(1, 1'b1, 10, n);   check("rerst_blank_rise", 32'(n), 32'd2);
        wait_for(0, 1'b0, 2000, n); check("rerst_hs_fall", 32'(n), 32'd1312);
        check("rerst_vs", 32'(ifa.VGA_VS), 32'd1);

        // ---- Instance B: three shrunken frames, per-clk reference model ----
        fs_count  = 0;
        fs_first  = 0;
        fs_second = 0;
        bn_clks   = 0;
        hs_clks   = 0;
        vs_clks   = 0;
        @(negedge clk);
        resetn_b = 1'b1;
        for (int c = 1; c < 3 * 1280; c++) begin
            @(posedge clk);
            #1;
            if (c < 2) begin
                e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_vb = 1'b0;
            end else begin
                p = (c / 2) - 1;
                h = p % 32;
                v = (p / 32) % 20;
                e_hs = !(h >= 20 && h < 28);
                e_vs = !(v >= 14 && v < 16);
                e_bn = (h < 16) && (v < 12);
                e_vb = (v >= 12);
            end
            e_fs = (c == 1280) || (c == 2560);
            check("b_hs", 32'(ifb.VGA_HS), 32'(e_hs));
            check("b_vs", 32'(ifb.VGA_VS), 32'(e_vs));
            check("b_blank_n", 32'(ifb.VGA_BLANK_N), 32'(e_bn));
            check("b_vblank", 32'(ifb.vblank), 32'(e_vb));
            check("b_frame_start", 32'(ifb.frame_start), 32'(e_fs));
            check("b_vga_clk", 32'(ifb.VGA_CLK), 32'(c % 2));
            check("b_red", 32'(ifb.VGA_R), e_bn ? 32'h3FF : 32'd0);
            check("b_green", 32'(ifb.VGA_G), e_bn ? 32'h3FF : 32'd0);
            check("b_blue", 32'(ifb.VGA_B), e_bn ? 32'h3FF : 32'd0);
            check("b_vblank_vs_blank", 32'(ifb.vblank & ifb.VGA_BLANK_N), 32'd0);
            if (ifb.frame_start === 1'b1) begin
                fs_count++;
                if (fs_count == 1) fs_first = c;
                else fs_second = c;
            end
            if (c <= 1281) begin
                if (ifb.VGA_BLANK_N === 1'b1) bn_clks++;
                if (ifb.VGA_HS === 1'b0) hs_clks++;
                if (ifb.VGA_VS === 1'b0) vs_clks++;
            end
        end
        check("b_fs_count", 32'(fs_count), 32'd2);
        check("b_fs_spacing", 32'(fs_second - fs_first), 32'd1280);
        check("b_blank_clks", 32'(bn_clks), 32'd384);
        check("b_hs_clks", 32'(hs_clks), 32'd320);
        check("b_vs_clks", 32'(vs_clks), 32'd128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
